// File: rtl/capture_readout_controller_pkg.sv
// Shared definitions for the capture/readout sequencer: state encoding and defaults.
package capture_readout_controller_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ARM      = 4'd1,
    ST_FILL     = 4'd2,
    ST_WAIT_RDY = 4'd3,
    ST_READ     = 4'd4,
    ST_WAIT_VLD = 4'd5,
    ST_SEND     = 4'd6,
    ST_WAIT_TX  = 4'd7,
    ST_DONE     = 4'd8
  } state_e;

  localparam int unsigned READ_BYTES_DEF = 4096;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/capture_readout_controller_sync_2ff.sv
// Two-flop synchroniser for a single level signal crossing from the store write clock.
module capture_readout_controller_sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/capture_readout_controller.sv
// Sequences one capture of the sample store, then drains READ_BYTES bytes to the UART transmitter.
module capture_readout_controller
  import capture_readout_controller_pkg::*;
#(
  parameter int unsigned READ_BYTES    = READ_BYTES_DEF,
  parameter int unsigned CNT_W         = 13,
  parameter int unsigned FILL_TIMEOUT  = 65535,
  parameter int unsigned VALID_TIMEOUT = 16
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       StartCapture,
  input  logic       Abort,
  input  logic       FifoNotFull,
  input  logic       DataReadyToSend,
  input  logic       DataValid,
  input  logic [7:0] DataOut,
  input  logic       TxBusy,
  output logic       WriteEnableOut,
  output logic       ReadEnable,
  output logic [7:0] TxData,
  output logic       TxStart,
  output logic       Busy,
  output logic       Done,
  output logic       Error
);

  localparam int unsigned TO_W = $clog2(max_u(FILL_TIMEOUT, VALID_TIMEOUT) + 1);
  localparam logic [TO_W-1:0]  FILL_LAST = TO_W'(FILL_TIMEOUT - 1);
  localparam logic [TO_W-1:0]  VLD_LAST  = TO_W'(VALID_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(READ_BYTES - 1);

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        txd_q, txd_d;
  logic              read_en, tx_start, done;
  logic              fnf_sync, drs_sync, full_s;

  capture_readout_controller_sync_2ff u_fnf_sync (
    .clk (Clock), .rst (Reset), .d (FifoNotFull), .q (fnf_sync)
  );

  capture_readout_controller_sync_2ff u_drs_sync (
    .clk (Clock), .rst (Reset), .d (DataReadyToSend), .q (drs_sync)
  );

  assign full_s = !fnf_sync;

  function automatic logic [TO_W-1:0] sat_inc(input logic [TO_W-1:0] v);
    return (v == '1) ? v : v + TO_W'(1);
  endfunction

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    err_d    = err_q;
    to_d     = to_q;
    cnt_d    = cnt_q;
    txd_d    = txd_q;
    read_en  = 1'b0;
    tx_start = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (StartCapture) begin
          err_d   = 1'b0;
          state_d = ST_ARM;
        end
      end
      ST_ARM: begin
        we_d    = 1'b1;
        to_d    = '0;
        state_d = ST_FILL;
      end
      ST_FILL: begin
        if (full_s) begin
          we_d    = 1'b0;
          to_d    = '0;
          state_d = ST_WAIT_RDY;
        end else if (to_q == FILL_LAST) begin
          we_d    = 1'b0;
          err_d   = 1'b1;
          to_d    = '0;
          state_d = ST_IDLE;
        end else begin
          to_d = sat_inc(to_q);
        end
      end
      ST_WAIT_RDY: begin
        if (drs_sync) state_d = ST_READ;
      end
      ST_READ: begin
        read_en = 1'b1;
        to_d    = '0;
        state_d = ST_WAIT_VLD;
      end
      ST_WAIT_VLD: begin
        if (DataValid) begin
          txd_d   = DataOut;
          to_d    = '0;
          state_d = ST_SEND;
        end else if (to_q == VLD_LAST) begin
          err_d   = 1'b1;
          to_d    = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          to_d = sat_inc(to_q);
        end
      end
      ST_SEND: begin
        if (!TxBusy) begin
          tx_start = 1'b1;
          to_d     = '0;
          state_d  = ST_WAIT_TX;
        end
      end
      ST_WAIT_TX: begin
        // to_q == 0 marks the first cycle, when the transmitter has not yet raised TxBusy
        if (to_q == '0) begin
          to_d = TO_W'(1);
        end else if (!TxBusy) begin
          to_d = '0;
          if (cnt_q == BYTE_LAST) begin
            state_d = ST_DONE;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = ST_READ;
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort wins over everything, including a StartCapture in the same cycle
    if (Abort) begin
      state_d = ST_IDLE;
      we_d    = 1'b0;
      err_d   = err_q;
      to_d    = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      to_q    <= '0;
      cnt_q   <= '0;
      txd_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      err_q   <= err_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
      txd_q   <= txd_d;
    end
  end

  assign WriteEnableOut = we_q;
  assign ReadEnable     = read_en;
  assign TxData         = txd_q;
  assign TxStart        = tx_start;
  assign Busy           = (state_q != ST_IDLE);
  assign Done           = done;
  assign Error          = err_q;

endmodule
